// File: rtl/microwave_timer.sv
// microwave_timer: keypad MM:SS entry (BCD digits shifted in from the right) and once-per-second BCD countdown.
// Optional feature macro: QUICK_START_EN -- Start in IDLE at 00:00 loads 00:30 and runs.
module microwave_timer #(
    parameter int unsigned TICKS_PER_SEC = 100000000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] Key,
    input  logic       KeyValid,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Clear,
    output logic [3:0] TenMin,
    output logic [3:0] Min,
    output logic [3:0] TenSec,
    output logic [3:0] Sec,
    output logic       Running,
    output logic       Paused,
    output logic       Done
);
    localparam int unsigned PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t        r_state, w_state;
    logic [PW-1:0] r_presc, w_presc;
    logic [3:0]    r_tm, r_mn, r_ts, r_sc;
    logic [3:0]    w_tm, w_mn, w_ts, w_sc;
    logic [3:0]    w_dec_tm, w_dec_mn, w_dec_ts, w_dec_sc;
    logic          w_time_zero, w_dec_zero, w_wrap;
    logic          r_running, r_paused, r_done;

    assign w_time_zero = (r_tm == '0) && (r_mn == '0) && (r_ts == '0) && (r_sc == '0);
    assign w_dec_zero  = (w_dec_tm == '0) && (w_dec_mn == '0) && (w_dec_ts == '0) && (w_dec_sc == '0);
    assign w_wrap      = (r_presc == LAST);

    // One-second BCD decrement: seconds borrow 0->9, ten-seconds 0->5, minutes 0->9.
    always_comb begin
        w_dec_sc = r_sc - 4'd1;
        w_dec_ts = r_ts;
        w_dec_mn = r_mn;
        w_dec_tm = r_tm;
        if (r_sc == '0) begin
            w_dec_sc = 4'd9;
            if (r_ts != '0) begin
                w_dec_ts = r_ts - 4'd1;
            end else begin
                w_dec_ts = 4'd5;
                if (r_mn != '0) begin
                    w_dec_mn = r_mn - 4'd1;
                end else begin
                    w_dec_mn = 4'd9;
                    w_dec_tm = r_tm - 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_presc = r_presc;
        w_tm    = r_tm;
        w_mn    = r_mn;
        w_ts    = r_ts;
        w_sc    = r_sc;
        if (Clear) begin
            w_state = S_IDLE;
            w_presc = '0;
            {w_tm, w_mn, w_ts, w_sc} = '0;
        end else if (Stop) begin
            if (r_state == S_RUN) begin
                w_state = S_PAUSE;
            end else begin
                w_state = S_IDLE;
                {w_tm, w_mn, w_ts, w_sc} = '0;
            end
        end else begin
            if (Start && r_state == S_IDLE) begin
                if (!w_time_zero) begin
                    w_state = S_RUN;
                    w_presc = '0;
                end
`ifdef QUICK_START_EN
                else begin
                    w_state = S_RUN;
                    w_presc = '0;
                    {w_tm, w_mn, w_ts, w_sc} = 16'h0030;
                end
`endif
            end else if (Start && r_state == S_PAUSE) begin
                w_state = S_RUN;
            end else if (!Start && KeyValid && Key <= 4'd9 &&
                         (r_state == S_IDLE || r_state == S_DONE)) begin
                w_state = S_IDLE;
                {w_tm, w_mn, w_ts, w_sc} = {r_mn, r_ts, r_sc, Key};
            end
            // Start in RUN is a no-op, so the countdown still advances alongside it.
            if (r_state == S_RUN) begin
                if (w_wrap) begin
                    w_presc = '0;
                    {w_tm, w_mn, w_ts, w_sc} = {w_dec_tm, w_dec_mn, w_dec_ts, w_dec_sc};
                    if (w_dec_zero) w_state = S_DONE;
                end else begin
                    w_presc = r_presc + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_tm      <= '0;
            r_mn      <= '0;
            r_ts      <= '0;
            r_sc      <= '0;
            r_running <= 1'b0;
            r_paused  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_presc   <= w_presc;
            r_tm      <= w_tm;
            r_mn      <= w_mn;
            r_ts      <= w_ts;
            r_sc      <= w_sc;
            r_running <= (w_state == S_RUN);
            r_paused  <= (w_state == S_PAUSE);
            r_done    <= (w_state == S_DONE);
        end
    end

    assign TenMin  = r_tm;
    assign Min     = r_mn;
    assign TenSec  = r_ts;
    assign Sec     = r_sc;
    assign Running = r_running;
    assign Paused  = r_paused;
    assign Done    = r_done;
endmodule

// File: tb/tb_microwave_timer.sv
// Bench for microwave_timer with TICKS_PER_SEC=4: directed keypad/start/stop scenarios checked
// every cycle against an arithmetic MM:SS model, plus hand-computed literal expectations.
module tb_microwave_timer;
    localparam int T = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] Key = '0;
    logic       KeyValid = 1'b0, Start = 1'b0, Stop = 1'b0, Clear = 1'b0;
    logic [3:0] TenMin, Min, TenSec, Sec;
    logic       Running, Paused, Done;

    int total = 0;
    int bad = 0;

    microwave_timer #(.TICKS_PER_SEC(T)) dut (
        .Clk(Clk), .Reset(Reset), .Key(Key), .KeyValid(KeyValid),
        .Start(Start), .Stop(Stop), .Clear(Clear),
        .TenMin(TenMin), .Min(Min), .TenSec(TenSec), .Sec(Sec),
        .Running(Running), .Paused(Paused), .Done(Done)
    );

    always #5 Clk = ~Clk;

    // Model: the setting is a 4-digit decimal number MMSS; minutes and seconds are plain integers.
    int m_mode = M_IDLE;
    int m_val = 0;
    int m_elapsed = 0;
    int m_mm, m_ss;
    bit m_was_run;

    function automatic logic [15:0] dig_of(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(posedge Clk) begin
        m_was_run = (m_mode == M_RUN);
        if (Reset) begin
            m_mode = M_IDLE; m_val = 0; m_elapsed = 0;
        end else if (Clear) begin
            m_mode = M_IDLE; m_val = 0; m_elapsed = 0;
        end else if (Stop) begin
            if (m_mode == M_RUN) m_mode = M_PAUSE;
            else begin m_mode = M_IDLE; m_val = 0; end
        end else begin
            if (Start) begin
                if (m_mode == M_IDLE && m_val != 0) begin
                    m_mode = M_RUN; m_elapsed = 0;
                end else if (m_mode == M_PAUSE) begin
                    m_mode = M_RUN;
                end
`ifdef QUICK_START_EN
                else if (m_mode == M_IDLE) begin
                    m_val = 30; m_mode = M_RUN; m_elapsed = 0;
                end
`endif
            end else if (KeyValid && Key <= 4'd9 && (m_mode == M_IDLE || m_mode == M_DONE)) begin
                m_val = (m_val * 10 + int'(Key)) % 10000;
                m_mode = M_IDLE;
            end
            if (m_was_run) begin
                if (m_elapsed == T - 1) begin
                    m_elapsed = 0;
                    m_mm = m_val / 100;
                    m_ss = m_val % 100;
                    if (m_ss > 0) m_ss = m_ss - 1;
                    else begin m_ss = 59; m_mm = m_mm - 1; end
                    m_val = m_mm * 100 + m_ss;
                    if (m_val == 0) m_mode = M_DONE;
                end else begin
                    m_elapsed = m_elapsed + 1;
                end
            end
        end
        #1;
        total++;
        if ({TenMin, Min, TenSec, Sec} !== dig_of(m_val)) begin
            bad++;
            $display("FAIL model_digits t=%0t got=%h want=%h", $time, {TenMin, Min, TenSec, Sec}, dig_of(m_val));
        end
        total++;
        if ({Running, Paused, Done} !== {m_mode == M_RUN, m_mode == M_PAUSE, m_mode == M_DONE}) begin
            bad++;
            $display("FAIL model_status t=%0t got=%b want=%b", $time, {Running, Paused, Done},
                     {m_mode == M_RUN, m_mode == M_PAUSE, m_mode == M_DONE});
        end
    end

    task automatic lit(input string nm, input logic [15:0] dig, input logic [2:0] st);
        total++;
        if ({TenMin, Min, TenSec, Sec} !== dig || {Running, Paused, Done} !== st) begin
            bad++;
            $display("FAIL %s: got %h run/pause/done=%b, want %h %b", nm,
                     {TenMin, Min, TenSec, Sec}, {Running, Paused, Done}, dig, st);
        end
    endtask

    task automatic cyc(input logic kv, input logic [3:0] k, input logic st, input logic sp, input logic cl);
        KeyValid = kv; Key = k; Start = st; Stop = sp; Clear = cl;
        @(negedge Clk);
        KeyValid = 1'b0; Key = '0; Start = 1'b0; Stop = 1'b0; Clear = 1'b0;
    endtask

    task automatic key(input logic [3:0] k); cyc(1'b1, k, 1'b0, 1'b0, 1'b0); endtask
    task automatic start(); cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); endtask
    task automatic stop(); cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0); endtask
    task automatic clear(); cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1); endtask
    task automatic idle(input int n); repeat (n) @(negedge Clk); endtask

    initial begin
        idle(2);
        lit("reset", 16'h0000, 3'b000);
        Reset = 1'b0;

        key(4'd1); key(4'd3); key(4'd0); key(4'd12);
        lit("entry_0130", 16'h0130, 3'b000);
        start();
        lit("start_run", 16'h0130, 3'b100);
        idle(3);
        lit("before_tick", 16'h0130, 3'b100);
        idle(1);
        lit("tick_0129", 16'h0129, 3'b100);
        clear();
        lit("clear_run", 16'h0000, 3'b000);

        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        lit("shift_2345", 16'h2345, 3'b000);
        stop();
        lit("stop_idle_zero", 16'h0000, 3'b000);

        key(4'd1); key(4'd0); key(4'd0); start(); idle(4);
        lit("borrow_0059", 16'h0059, 3'b100);
        clear();
        key(4'd9); key(4'd0); start(); idle(3); start();
        lit("start_on_wrap_0089", 16'h0089, 3'b100);
        clear();

        key(4'd2); start(); idle(4);
        lit("count_0001", 16'h0001, 3'b100);
        idle(4);
        lit("done", 16'h0000, 3'b001);
        idle(2);
        lit("done_hold", 16'h0000, 3'b001);
        key(4'd5);
        lit("done_key", 16'h0005, 3'b000);
        clear();

        key(4'd1); key(4'd3); key(4'd0); start(); idle(2); stop();
        lit("pause", 16'h0130, 3'b010);
        idle(3);
        lit("pause_hold", 16'h0130, 3'b010);
        start();
        lit("resume", 16'h0130, 3'b100);
        idle(1);
        lit("resume_pre", 16'h0130, 3'b100);
        idle(1);
        lit("resume_tick", 16'h0129, 3'b100);
        stop();
        stop();
        lit("cancel", 16'h0000, 3'b000);

        key(4'd5); start(); idle(1); key(4'd8); idle(1); stop();
        lit("stop_on_wrap", 16'h0005, 3'b010);
        stop();
        key(4'd5); start(); idle(3); cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        lit("clear_on_wrap", 16'h0000, 3'b000);

        key(4'd7); start(); idle(2);
        Reset = 1'b1;
        @(negedge Clk);
        lit("reset_in_run", 16'h0000, 3'b000);
        Reset = 1'b0;

        start();
`ifdef QUICK_START_EN
        lit("quick_start", 16'h0030, 3'b100);
        idle(4);
        lit("quick_tick", 16'h0029, 3'b100);
`else
        lit("no_quick_start", 16'h0000, 3'b000);
        idle(4);
        lit("no_quick_hold", 16'h0000, 3'b000);
`endif
        clear();
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
